// File: rtl/ballot_controller.sv
`default_nettype none
// ============================================================================
// Module   : ballot_controller
// Purpose  : One-voter-at-a-time ballot sequencer with saturating tallies,
//            post-vote lockout and an optional ARMED timeout
//            (enabled by defining VOTE_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module ballot_controller #(
    parameter int LOCKOUT_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_VOTES      = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       arm,
    input  logic       candidate1_button,
    input  logic       candidate2_button,
    input  logic       candidate3_button,
    output logic       valid_vote_casted,
    output logic [1:0] cast_id,
    output logic [6:0] candidate1_vote,
    output logic [6:0] candidate2_vote,
    output logic [6:0] candidate3_vote,
    output logic       reject,
    output logic       timeout,
    output logic       overflow,
    output logic [1:0] state
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ARMED     = 2'd1;
    localparam logic [1:0] c_LOCKOUT   = 2'd2;
    localparam logic [7:0] c_LOCK_LOAD = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [6:0] c_MAX       = 7'(MAX_VOTES);

    // Elaboration-time parameter range guards
    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 255) begin : g_bad_lockout
        $error("ballot_controller: LOCKOUT_CYCLES must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("ballot_controller: TIMEOUT_CYCLES must be 1..65535");
    end
    if (MAX_VOTES < 1 || MAX_VOTES > 99) begin : g_bad_max
        $error("ballot_controller: MAX_VOTES must be 1..99");
    end

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [2:0] w_btn;
    logic [2:0] r_btn;
    logic [2:0] r_prev;
    logic [2:0] w_rise;
    logic       w_any_rise;
    logic       w_clean;
    logic [7:0] r_lock_cnt;
    logic [7:0] w_lock_next;
    logic [2:0] w_accept;
    logic [2:0] w_at_max;
    logic       w_reject;
    logic       w_expire;
    logic       w_tmo_done;
    logic       r_valid;
    logic       r_reject;
    logic       r_timeout;
    logic       r_overflow;
    logic [1:0] r_cast_id;
    logic [6:0] r_tally [3];

    // Buttons are registered once, then again into prev; the rise is judged
    // one cycle after the level is first sampled.
    assign w_btn      = {candidate3_button, candidate2_button, candidate1_button};
    assign w_rise     = r_btn & ~r_prev;
    assign w_any_rise = |w_rise;
    assign w_clean    = w_any_rise && ((w_rise & (w_rise - 3'd1)) == 3'd0)
                        && (r_btn == w_rise);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn  <= 3'b111;
            r_prev <= 3'b111;
        end else begin
            r_btn  <= w_btn;
            r_prev <= r_btn;
        end
    end

`ifdef VOTE_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clock) begin
        if (reset || r_state != c_ARMED || w_state_next != c_ARMED) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo_done = (r_state == c_ARMED) && (r_tmo_cnt == c_TMO_LAST);
`else
    assign w_tmo_done = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_lock_next  = r_lock_cnt;
        w_accept     = 3'b000;
        w_reject     = 1'b0;
        w_expire     = 1'b0;
        if (mode) begin
            w_state_next = c_IDLE;
            w_lock_next  = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (arm) begin
                        w_state_next = c_ARMED;
                    end
                end
                c_ARMED: begin
                    if (w_clean) begin
                        w_accept     = w_rise;
                        w_state_next = c_LOCKOUT;
                        w_lock_next  = c_LOCK_LOAD;
                    end else begin
                        w_reject = w_any_rise;
                        if (w_tmo_done) begin
                            w_expire     = 1'b1;
                            w_state_next = c_IDLE;
                        end
                    end
                end
                c_LOCKOUT: begin
                    if (r_lock_cnt == 8'd0) begin
                        w_state_next = c_IDLE;
                    end else begin
                        w_lock_next = r_lock_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_lock_cnt <= '0;
            r_valid    <= 1'b0;
            r_reject   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_lock_cnt <= w_lock_next;
            r_valid    <= |w_accept;
            r_reject   <= w_reject;
            r_timeout  <= w_expire;
        end
    end

    always_comb begin
        w_at_max = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_at_max[i] = (r_tally[i] == c_MAX);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_tally[i] <= '0;
            end
            r_overflow <= 1'b0;
            r_cast_id  <= 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_accept[i] && !w_at_max[i]) begin
                    r_tally[i] <= r_tally[i] + 7'd1;
                end
            end
            if (|(w_accept & w_at_max)) begin
                r_overflow <= 1'b1;
            end
            // One-hot accept bit 0/1/2 encodes to candidate id 1/2/3
            if (|w_accept) begin
                r_cast_id <= {w_accept[2] | w_accept[1], w_accept[2] | w_accept[0]};
            end
        end
    end

    assign valid_vote_casted = r_valid;
    assign reject            = r_reject;
    assign timeout           = r_timeout;
    assign overflow          = r_overflow;
    assign cast_id           = r_cast_id;
    assign state             = r_state;
    assign candidate1_vote   = r_tally[0];
    assign candidate2_vote   = r_tally[1];
    assign candidate3_vote   = r_tally[2];

endmodule
`default_nettype wire

// File: tb/tb_ballot_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ballot_controller
// Purpose  : Scoreboard bench for ballot_controller; strobes are checked by a
//            monitor against expectations queued by the stimulus process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ballot_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode  = 1'b0;
    logic       arm   = 1'b0;
    logic       candidate1_button = 1'b0;
    logic       candidate2_button = 1'b0;
    logic       candidate3_button = 1'b0;
    logic       valid_vote_casted;
    logic [1:0] cast_id;
    logic [6:0] candidate1_vote;
    logic [6:0] candidate2_vote;
    logic [6:0] candidate3_vote;
    logic       reject;
    logic       timeout;
    logic       overflow;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] strobes;   // {valid, reject, timeout}
        logic [1:0] id;
        logic [6:0] t1;
        logic [6:0] t2;
        logic [6:0] t3;
        logic       ovf;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int         m_t [1:3];
    logic [1:0] m_id;
    logic       m_ovf;

    ballot_controller #(
        .LOCKOUT_CYCLES(4),
        .TIMEOUT_CYCLES(10),
        .MAX_VOTES(99)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mode(mode),
        .arm(arm),
        .candidate1_button(candidate1_button),
        .candidate2_button(candidate2_button),
        .candidate3_button(candidate3_button),
        .valid_vote_casted(valid_vote_casted),
        .cast_id(cast_id),
        .candidate1_vote(candidate1_vote),
        .candidate2_vote(candidate2_vote),
        .candidate3_vote(candidate3_vote),
        .reject(reject),
        .timeout(timeout),
        .overflow(overflow),
        .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_btn(input int c, input logic v);
        case (c)
            1: candidate1_button = v;
            2: candidate2_button = v;
            default: candidate3_button = v;
        endcase
    endtask

    task automatic model_reset();
        m_t[1] = 0; m_t[2] = 0; m_t[3] = 0;
        m_id = 2'd0; m_ovf = 1'b0;
    endtask

    task automatic push(input logic [2:0] strobes, input logic [1:0] st);
        exp_t e;
        e.strobes = strobes; e.id = m_id; e.ovf = m_ovf; e.st = st;
        e.t1 = 7'(m_t[1]); e.t2 = 7'(m_t[2]); e.t3 = 7'(m_t[3]);
        sb.push_back(e);
    endtask

    task automatic expect_vote(input int c);
        if (m_t[c] == 99) m_ovf = 1'b1;
        else m_t[c] = m_t[c] + 1;
        m_id = 2'(c);
        push(3'b100, 2'd2);
    endtask

    // Arm and press together; rise is judged in ARMED one edge later
    task automatic cast(input int c);
        set_btn(c, 1'b1);
        arm = 1'b1;
        expect_vote(c);
        tick();
        arm = 1'b0;
        tick();
        set_btn(c, 1'b0);
        tick(5);
        chk("cast_back_to_idle", state, 0);
    endtask

    always @(negedge clock) begin
        if (!reset && (valid_vote_casted || reject || timeout)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got valid=%0b reject=%0b timeout=%0b expected none",
                         valid_vote_casted, reject, timeout);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_strobes", {valid_vote_casted, reject, timeout}, mon_e.strobes);
                chk("sb_cast_id", cast_id, mon_e.id);
                chk("sb_tally1", candidate1_vote, mon_e.t1);
                chk("sb_tally2", candidate2_vote, mon_e.t2);
                chk("sb_tally3", candidate3_vote, mon_e.t3);
                chk("sb_overflow", overflow, mon_e.ovf);
                chk("sb_state", state, mon_e.st);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        tick(3);
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_tally1", candidate1_vote, 0);
        chk("rst_tally2", candidate2_vote, 0);
        chk("rst_tally3", candidate3_vote, 0);
        chk("rst_cast_id", cast_id, 0);
        chk("rst_strobes", {valid_vote_casted, reject, timeout}, 0);
        chk("rst_overflow", overflow, 0);

        // Candidate 2 held for three cycles: one vote, lockout of four cycles
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_after_arm", state, 1);
        candidate2_button = 1'b1;
        expect_vote(2);
        tick(2);
        chk("lockout_entered", state, 2);
        tick();
        candidate2_button = 1'b0;
        tick(2);
        chk("lockout_last_cycle", state, 2);
        tick();
        chk("lockout_exit", state, 0);

        // Simultaneous rises on 1 and 3 reject; lone 3 then counts
        arm = 1'b1;
        tick();
        arm = 1'b0;
        candidate1_button = 1'b1;
        candidate3_button = 1'b1;
        push(3'b010, 2'd1);
        tick(2);
        candidate1_button = 1'b0;
        candidate3_button = 1'b0;
        tick();
        candidate3_button = 1'b1;
        expect_vote(3);
        tick(2);
        candidate3_button = 1'b0;
        tick(5);
        chk("after_reject_vote_idle", state, 0);

        // Presses in IDLE are ignored
        candidate1_button = 1'b1;
        tick(3);
        candidate1_button = 1'b0;
        tick(2);
        chk("idle_press_tally1", candidate1_vote, m_t[1]);

        // Press during LOCKOUT is ignored
        arm = 1'b1;
        candidate1_button = 1'b1;
        expect_vote(1);
        tick();
        arm = 1'b0;
        tick();
        candidate1_button = 1'b0;
        candidate3_button = 1'b1;
        tick(2);
        candidate3_button = 1'b0;
        tick(4);
        chk("lockout_press_state", state, 0);
        chk("lockout_press_tally3", candidate3_vote, m_t[3]);

        // Button held through reset release, armed immediately: no vote
        candidate2_button = 1'b1;
        reset = 1'b1;
        tick(2);
        model_reset();
        reset = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(3);
        chk("held_reset_still_armed", state, 1);
        chk("held_reset_tally2", candidate2_vote, 0);
        candidate2_button = 1'b0;
        tick();

        // mode=1 drops ARMED to IDLE; later press ignored until re-armed
        mode = 1'b1;
        tick();
        mode = 1'b0;
        chk("mode_to_idle", state, 0);
        candidate1_button = 1'b1;
        tick(2);
        candidate1_button = 1'b0;
        tick(2);
        chk("mode_press_ignored", candidate1_vote, 0);
        cast(1);

        // Reset in the middle of LOCKOUT
        arm = 1'b1;
        candidate3_button = 1'b1;
        expect_vote(3);
        tick();
        arm = 1'b0;
        tick();
        candidate3_button = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        model_reset();
        chk("midlock_rst_state", state, 0);
        chk("midlock_rst_tallies", {candidate1_vote, candidate2_vote, candidate3_vote}, 0);
        chk("midlock_rst_cast_id", cast_id, 0);
        chk("midlock_rst_flags", {valid_vote_casted, reject, timeout, overflow}, 0);
        reset = 1'b0;
        tick(2);

        // Saturation: 99 votes fill the tally, the 100th overflows
        for (int i = 0; i < 100; i++) cast(1);
        chk("sat_tally1", candidate1_vote, 99);
        chk("sat_overflow", overflow, 1);
        cast(2);
        chk("sat_overflow_sticky", overflow, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_reset();
        chk("sat_overflow_cleared", overflow, 0);
        chk("sat_tally1_cleared", candidate1_vote, 0);

`ifdef VOTE_TIMEOUT_EN
        // ARMED expires after ten cycles
        arm = 1'b1;
        tick();
        arm = 1'b0;
        push(3'b001, 2'd0);
        tick(9);
        chk("tmo_still_armed", state, 1);
        tick();
        chk("tmo_idle", state, 0);
        tick(2);
        // Vote on the expiry cycle wins
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(8);
        candidate1_button = 1'b1;
        expect_vote(1);
        tick(2);
        candidate1_button = 1'b0;
        chk("tmo_vote_wins_state", state, 2);
        tick(5);
`endif

        tick(2);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
